slow_memory: RTL and testbench

Behavioural slow off-chip memory model with a 128-bit line interface. It serves line-granular read/write requests after a fixed multi-cycle latency and signals completion with a one-cycle ready pulse. In the system testbench, two instances sit outside CHIP: one backs the data cache and one backs the instruction cache. Contents are preloaded by the bench through the storage array `mem`.

---
 rtl/slow_memory.sv | 143 ++++++++++++++
 tb/tb_slow_memory.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/slow_memory.sv
// slow_memory: behavioural slow off-chip line memory with a fixed request latency.
// A request accepted in IDLE completes LATENCY edges later with a one-cycle
// mem_ready pulse; the storage array mem may be preloaded by the bench.
// Optional build macro: SLOW_MEM_PROTO_CHECK_EN adds a simulation-only
// handshake checker with a sticky proto_err flag.
module slow_memory #(
  parameter int unsigned MEM_NUM   = 256,
  parameter int unsigned MEM_WIDTH = 128,
  parameter int unsigned LATENCY   = 15
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 mem_read,
  input  logic                 mem_write,
  input  logic [27:0]          mem_addr,
  input  logic [MEM_WIDTH-1:0] mem_wdata,
  output logic [MEM_WIDTH-1:0] mem_rdata,
  output logic                 mem_ready
);

  localparam int unsigned IDX_W = $clog2(MEM_NUM);
  localparam int unsigned CNT_W = $clog2(LATENCY + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  logic [MEM_WIDTH-1:0] mem [0:MEM_NUM-1];

  state_t               state;
  state_t               state_nxt;
  logic [CNT_W-1:0]     cnt;
  logic [IDX_W-1:0]     idx_q;
  logic                 wr_q;
  logic [MEM_WIDTH-1:0] wdata_q;

  logic req_c;
  logic accept_c;
  logic finish_c;
  logic unused_addr_c;

  assign req_c         = mem_read | mem_write;
  // Upper line-address bits alias onto the same storage.
  assign unused_addr_c = ^mem_addr;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_c) state_nxt = WAIT;
      WAIT:    if (cnt == CNT_W'(LATENCY)) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Decoded control strobes for the datapath.
  always_comb begin
    accept_c = 1'b0;
    finish_c = 1'b0;
    if (state == IDLE && req_c) accept_c = 1'b1;
    if (state == WAIT && cnt == CNT_W'(LATENCY)) finish_c = 1'b1;
  end

  // Request capture, latency counter and registered response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      idx_q     <= '0;
      wr_q      <= 1'b0;
      wdata_q   <= '0;
      mem_ready <= 1'b0;
      mem_rdata <= '0;
    end else begin
      mem_ready <= finish_c;
      if (accept_c) begin
        cnt     <= CNT_W'(1);
        idx_q   <= mem_addr[IDX_W-1:0];
        wr_q    <= mem_write;
        wdata_q <= mem_wdata;
      end else if (finish_c) begin
        cnt <= '0;
      end else if (state == WAIT) begin
        cnt <= cnt + CNT_W'(1);
      end
      if (finish_c && !wr_q) begin
        mem_rdata <= mem[idx_q];
      end
    end
  end

  // Storage array; reset never touches contents, so an aborted write is lost.
  always_ff @(posedge clk) begin
    if (finish_c && wr_q) begin
      mem[idx_q] <= wdata_q;
    end
  end

`ifdef SLOW_MEM_PROTO_CHECK_EN
  logic        proto_err;
  logic [27:0] addr_chk_q;
  logic        after_done_q;

  // Simulation-only handshake checker with a sticky error flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      proto_err    <= 1'b0;
      addr_chk_q   <= '0;
      after_done_q <= 1'b0;
    end else begin
      after_done_q <= (state == DONE);
      if (accept_c) begin
        addr_chk_q <= mem_addr;
        if (mem_read && mem_write) begin
          $display("slow_memory: read and write both high at acceptance");
          proto_err <= 1'b1;
        end
      end
      if (state == WAIT && (!req_c || mem_addr != addr_chk_q || mem_write != wr_q)) begin
        $display("slow_memory: request dropped or changed while waiting");
        proto_err <= 1'b1;
      end
      if (state == IDLE && after_done_q && req_c) begin
        $display("slow_memory: request still held two edges after ready");
        proto_err <= 1'b1;
      end
    end
  end
`else
`endif

endmodule

// File: tb/tb_slow_memory.sv
// tb_slow_memory: directed and random line transactions against an
// array-based reference model of the slow memory.
module tb_slow_memory;

  localparam int unsigned L = 15;

  logic         clk = 1'b0;
  logic         rst;
  logic         mem_read;
  logic         mem_write;
  logic [27:0]  mem_addr;
  logic [127:0] mem_wdata;
  logic [127:0] mem_rdata;
  logic         mem_ready;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int last_ready_cyc = 0;

  logic [127:0] model_mem [0:255];
  logic [127:0] model_rdata;

  slow_memory #(
    .MEM_NUM  (256),
    .MEM_WIDTH(128),
    .LATENCY  (L)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .mem_read (mem_read),
    .mem_write(mem_write),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One transaction: drive, wait for the pulse, hold one edge past ready, release.
  task automatic do_op(input logic rd, input logic wr, input logic [27:0] addr,
                       input logic [127:0] wd);
    int n;
    logic [7:0] idx;
    idx = addr[7:0];
    if (wr) model_mem[idx] = wd;
    else if (rd) model_rdata = model_mem[idx];
    @(negedge clk);
    mem_read  = rd;
    mem_write = wr;
    mem_addr  = addr;
    mem_wdata = wd;
    @(posedge clk);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!mem_ready && n < 40);
    last_ready_cyc = cyc;
    chk("latency", 128'(n), 128'(L));
    chk("rdata", mem_rdata, model_rdata);
    @(posedge clk);
    #1;
    chk("ready_pulse", 128'(mem_ready), 128'd0);
    mem_read  = 1'b0;
    mem_write = 1'b0;
  endtask

  initial begin
    int r1;
    int k;
    logic [127:0] d;
    logic [127:0] pat5;
    logic [127:0] pat7;
    pat5 = 128'h0123456789ABCDEF0123456789ABCDEF;
    pat7 = 128'hA5A5A5A5A5A5A5A5A5A5A5A5A5A5A5A5;
    rst = 1'b1;
    mem_read = 1'b0;
    mem_write = 1'b0;
    mem_addr = '0;
    mem_wdata = '0;
    model_rdata = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ready", 128'(mem_ready), 128'd0);
    chk("reset_rdata", mem_rdata, 128'd0);
    @(negedge clk);
    rst = 1'b0;

    // Fill every line through the bus, with random alias bits on top.
    for (int i = 0; i < 256; i++) begin
      do_op(1'b0, 1'b1, {20'($urandom), 8'(i)}, rand128());
    end
    do_op(1'b0, 1'b1, 28'h5, pat5);

    // Plain read of a known line.
    do_op(1'b1, 1'b0, 28'h5, '0);
    chk("read5", mem_rdata, pat5);

    // Write then read back.
    do_op(1'b0, 1'b1, 28'h7, pat7);
    chk("mem7_array", dut.mem[7], pat7);
    do_op(1'b1, 1'b0, 28'h7, '0);
    chk("read7", mem_rdata, pat7);

    // Aliased address.
    do_op(1'b1, 1'b0, 28'h105, '0);
    chk("alias105", mem_rdata, pat5);

    // Read and write together behave as a write; rdata keeps the last read.
    d = rand128();
    do_op(1'b1, 1'b1, 28'h3, d);
    chk("both_rdata_kept", mem_rdata, pat5);
    chk("both_mem3", dut.mem[3], d);
    do_op(1'b1, 1'b0, 28'h3, '0);

    // Back-to-back with the request held one edge past ready.
    do_op(1'b1, 1'b0, 28'h20, '0);
    r1 = last_ready_cyc;
    do_op(1'b1, 1'b0, 28'h21, '0);
    chk("b2b_spacing", 128'(last_ready_cyc - r1), 128'(L + 2));

    // Random mix against the model.
    for (int i = 0; i < 40; i++) begin
      k = int'($urandom_range(0, 2));
      do_op(k != 1, k != 0, 28'($urandom), rand128());
    end

    // Abort a pending write at counter 8.
    @(negedge clk);
    mem_read  = 1'b0;
    mem_write = 1'b1;
    mem_addr  = 28'h9;
    mem_wdata = ~model_mem[9];
    @(posedge clk);
    repeat (7) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    mem_write = 1'b0;
    #1;
    chk("abort_ready", 128'(mem_ready), 128'd0);
    chk("abort_rdata", mem_rdata, 128'd0);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      chk("abort_ready_hold", 128'(mem_ready), 128'd0);
    end
    chk("abort_mem9", dut.mem[9], model_mem[9]);
    model_rdata = '0;
    @(negedge clk);
    rst = 1'b0;
    do_op(1'b1, 1'b0, 28'h9, '0);
    chk("post_abort_read9", mem_rdata, model_mem[9]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
